stencil_out_collector: RTL and testbench

- Output-side counterpart of the stencil input streamer: accepts the ST-lane result groups produced by the 2D stencil datapath, one column-group per valid beat.
- Reassembles the groups into full rows of COLUMNS words in a two-bank ping-pong row buffer.
- Drains each completed row one word per cycle over a valid/ready stream toward the result memory or the bench golden comparator.
- Flags row boundaries and frame completion (ROWS rows).

---
 rtl/stencil_out_collector.sv | 132 +++++++++++++
 tb/tb_stencil_out_collector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stencil_out_collector.sv
// Collects ST-lane stencil result beats into full rows using a two-bank ping-pong
// buffer, then drains each finished row one word per cycle over a valid/ready stream.
module stencil_out_collector #(
    parameter int BW      = 32,
    parameter int ST      = 3,
    parameter int COLUMNS = 6,
    parameter int ROWS    = 6,
    localparam int TILES  = (COLUMNS + ST - 1) / ST,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_collector_valid_in,
    input  logic [BW*ST-1:0] io_collector_data_in,
    output logic             io_collector_ready_out,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [BW-1:0]    io_out_data,
    output logic             io_out_last,
    output logic [RW-1:0]    io_out_row_idx,
    output logic             io_frame_done,
    output logic             debug_state
);
    localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int GW = (TILES > 1) ? $clog2(TILES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(COLUMNS - 1);
    localparam logic [GW-1:0] TILE_LAST = GW'(TILES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    // Both handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never depends on ready, and a producer holds its data until taken.
    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [BW-1:0]   bank [2][COLUMNS];
    logic [1:0]      full, full_set, full_clr;
    logic            wr_bank, rd_bank;
    logic [GW-1:0]   wr_grp;
    logic [CW-1:0]   rd_col, rd_col_nx;
    logic [RW-1:0]   row_cnt;
    logic            accept, row_done;

    assign io_collector_ready_out = reset & ~full[wr_bank];
    assign accept    = io_collector_valid_in & io_collector_ready_out;
    assign row_done  = (state == SEND) & io_out_ready & (rd_col == COL_LAST);
    assign rd_col_nx = rd_col + 1'b1;
    assign debug_state = state;

    // Set and clear always address different banks, since a full bank is never written.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (accept && wr_grp == TILE_LAST) full_set[wr_bank] = 1'b1;
        if (row_done)                      full_clr[rd_bank] = 1'b1;
    end

    // Lanes mapping past the last column have no storage slot and are dropped.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < COLUMNS; c++) begin
                    if (wr_bank == 1'(b) && wr_grp == GW'(c / ST))
                        bank[b][c] <= io_collector_data_in[(c % ST)*BW +: BW];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            full           <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_grp         <= '0;
            rd_col         <= '0;
            row_cnt        <= '0;
            io_out_valid   <= 1'b0;
            io_out_data    <= '0;
            io_out_last    <= 1'b0;
            io_out_row_idx <= '0;
            io_frame_done  <= 1'b0;
        end else begin
            full          <= (full | full_set) & ~full_clr;
            io_frame_done <= 1'b0;

            if (accept) begin
                if (wr_grp == TILE_LAST) begin
                    wr_bank <= ~wr_bank;
                    wr_grp  <= '0;
                end else begin
                    wr_grp  <= wr_grp + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state          <= SEND;
                        rd_col         <= '0;
                        io_out_valid   <= 1'b1;
                        io_out_data    <= bank[rd_bank][0];
                        io_out_last    <= (COL_LAST == '0);
                        io_out_row_idx <= row_cnt;
                    end
                end
                SEND: begin
                    if (io_out_ready) begin
                        if (rd_col == COL_LAST) begin
                            state        <= IDLE;
                            io_out_valid <= 1'b0;
                            io_out_data  <= '0;
                            io_out_last  <= 1'b0;
                            rd_bank      <= ~rd_bank;
                            if (row_cnt == ROW_LAST) begin
                                row_cnt       <= '0;
                                io_frame_done <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            rd_col      <= rd_col_nx;
                            io_out_data <= bank[rd_bank][rd_col_nx];
                            io_out_last <= (rd_col_nx == COL_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stencil_out_collector.sv
// Randomized bench for stencil_out_collector: a word-level row queue model predicts
// every drained word, its last flag, row index and the frame-done pulse.
module tb_stencil_out_collector;
    localparam int BW = 32, ST = 3, COLUMNS = 6, ROWS = 6;
    localparam int TILES = (COLUMNS + ST - 1) / ST;
    localparam int RW = $clog2(ROWS);

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic             valid_in = 1'b0;
    logic [BW*ST-1:0] data_in = '0;
    logic             ready_out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [BW-1:0]    out_data;
    logic             out_last;
    logic [RW-1:0]    out_row_idx;
    logic             frame_done;
    logic             dbg;

    stencil_out_collector #(.BW(BW), .ST(ST), .COLUMNS(COLUMNS), .ROWS(ROWS)) dut (
        .clock(clock), .reset(reset),
        .io_collector_valid_in(valid_in), .io_collector_data_in(data_in),
        .io_collector_ready_out(ready_out),
        .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_data(out_data),
        .io_out_last(out_last), .io_out_row_idx(out_row_idx),
        .io_frame_done(frame_done), .debug_state(dbg)
    );

    // Second instance with a partial last tile (5 columns, 2 beats of 3 lanes).
    logic             v5 = 1'b0;
    logic [BW*ST-1:0] d5 = '0;
    logic             r5, ov5, ol5, fd5, dbg5;
    logic             ord5 = 1'b1;
    logic [BW-1:0]    od5;
    logic [RW-1:0]    ori5;

    stencil_out_collector #(.BW(BW), .ST(ST), .COLUMNS(5), .ROWS(ROWS)) dut5 (
        .clock(clock), .reset(reset),
        .io_collector_valid_in(v5), .io_collector_data_in(d5),
        .io_collector_ready_out(r5),
        .io_out_valid(ov5), .io_out_ready(ord5), .io_out_data(od5),
        .io_out_last(ol5), .io_out_row_idx(ori5),
        .io_frame_done(fd5), .debug_state(dbg5)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [BW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            exp_row_q[$];
    int            model_row = 0;
    int            hs_cnt = 0;
    int            fd_cnt = 0;
    logic          exp_fd = 1'b0;
    logic          rand_ready = 1'b0;
    logic [BW-1:0] row_w [COLUMNS];
    logic [BW-1:0] got5[$];
    logic          last5[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A completed row contributes COLUMNS words in column order, tagged with its row.
    task automatic push_row();
        for (int i = 0; i < COLUMNS; i++) begin
            exp_q.push_back(row_w[i]);
            exp_last_q.push_back(i == COLUMNS - 1);
            exp_row_q.push_back(model_row);
        end
        model_row = (model_row + 1) % ROWS;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            hs_cnt = 0;
            exp_fd = 1'b0;
        end else begin
            check("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
            exp_fd = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("out_last", out_last, exp_last_q.pop_front());
                    check("out_row_idx", out_row_idx, exp_row_q.pop_front());
                end
                hs_cnt++;
                exp_fd = (hs_cnt % (ROWS * COLUMNS) == 0);
            end
        end
    end

    always @(negedge clock) begin
        if (reset && ov5 && ord5) begin
            got5.push_back(od5);
            last5.push_back(ol5);
        end
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [BW*ST-1:0] d);
        logic acc;
        int n;
        valid_in = 1'b1;
        data_in  = d;
        n = 0;
        do begin
            @(negedge clock);
            acc = ready_out;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        check("beat_accept", acc, 1);
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic send_row();
        logic [BW*ST-1:0] beat;
        for (int t = 0; t < TILES; t++) begin
            for (int k = 0; k < ST; k++) begin
                if (t * ST + k < COLUMNS) beat[k*BW +: BW] = row_w[t*ST + k];
                else                      beat[k*BW +: BW] = 32'hDEADBEEF;
            end
            drive_beat(beat);
        end
        push_row();
    endtask

    task automatic fill_random();
        for (int i = 0; i < COLUMNS; i++) row_w[i] = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_done", n < 400, 1);
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        exp_row_q.delete();
        model_row = 0;
        fd_cnt    = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic seen;
        int n;

        // Reset holds everything quiet even with valid_in asserted.
        valid_in = 1'b1;
        data_in  = {3{32'h12345678}};
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rst_ready", ready_out, 0);
            check("rst_valid", out_valid, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_data", out_data, 0);
            check("rst_row_idx", out_row_idx, 0);
            check("rst_last", out_last, 0);
        end
        @(posedge clock);
        #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        @(negedge clock);
        check("post_rst_ready", ready_out, 1);
        @(posedge clock);
        #1;

        // Single row of FP32 1.0 .. 6.0 with a fixed two-cycle first-word latency.
        row_w[0] = 32'h3F800000; row_w[1] = 32'h40000000; row_w[2] = 32'h40400000;
        row_w[3] = 32'h40800000; row_w[4] = 32'h40A00000; row_w[5] = 32'h40C00000;
        send_row();
        @(negedge clock);
        check("latency_n1_valid", out_valid, 0);
        @(negedge clock);
        check("latency_n2_valid", out_valid, 1);
        check("latency_n2_data", out_data, 32'h3F800000);
        wait_drain();

        // Partial final tile: the lane beyond column 4 must never surface.
        v5 = 1'b1;
        d5 = {32'h00000003, 32'h00000002, 32'h00000001};
        @(negedge clock);
        check("p5_ready_b1", r5, 1);
        @(posedge clock);
        #1;
        d5 = {32'hDEADBEEF, 32'h00000005, 32'h00000004};
        @(negedge clock);
        check("p5_ready_b2", r5, 1);
        @(posedge clock);
        #1;
        v5 = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        check("p5_count", got5.size(), 5);
        for (int i = 0; i < 5 && i < got5.size(); i++) begin
            check("p5_data", got5[i], i + 1);
            check("p5_last", last5[i], i == 4);
        end

        // Backpressure: two rows buffer, the third waits for a freed bank.
        out_ready = 1'b0;
        fill_random();
        send_row();
        fill_random();
        send_row();
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_ready_low", ready_out, 0);
            check("bp_valid", out_valid, 1);
            check("bp_hold_data", out_data, exp_q[0]);
        end
        @(posedge clock);
        #1;
        fork
            begin
                fill_random();
                send_row();
            end
            begin
                repeat (4) @(posedge clock);
                #1;
                out_ready = 1'b1;
                n = 0;
                seen = 1'b0;
                while (!seen && n < 50) begin
                    @(negedge clock);
                    seen = out_valid & out_ready & out_last;
                    n++;
                end
                check("bp_row0_last_seen", seen, 1);
                @(negedge clock);
                check("bp_ready_again", ready_out, 1);
            end
        join
        wait_drain();

        // Full frame plus one row under random downstream readiness.
        @(posedge clock);
        #1;
        apply_reset();
        rand_ready = 1'b1;
        for (int r = 0; r < ROWS + 1; r++) begin
            fill_random();
            send_row();
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        check("frame_pulse_count", fd_cnt, 1);
        check("frame_hs_count", hs_cnt, (ROWS + 1) * COLUMNS);

        // Reset mid-row discards the partial row; only the fresh row drains.
        @(posedge clock);
        #1;
        fill_random();
        drive_beat({row_w[2], row_w[1], row_w[0]});
        apply_reset();
        fill_random();
        send_row();
        wait_drain();
        repeat (5) @(posedge clock);
        #1;
        check("midrst_words", hs_cnt, COLUMNS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
